argmax: RTL and testbench
=========================

ARGMAX -- requirements
Module: argmax

Interface
REQ-001 Parameter k, default 100: number of elements in the input array; k SHALL be >= 2.
REQ-002 Parameter n, default 8: width of each element in bits; elements are two's-complement signed; n SHALL be >= 2.
REQ-003 Derived localparam IW = $clog2(k): index width; D = $clog2(k): tree depth and latency.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk_i  input  1  rising-edge clock.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 valid_i  input  1  array_i holds a new sample this cycle.
REQ-008 array_i  input  k*n  packed array; element j occupies bits [j*n +: n].
REQ-009 valid_o  output  1  index_o and max_o hold a result this cycle.
REQ-010 index_o  output  IW  index of the maximum element.
REQ-011 max_o  output  n  value of the maximum element, signed.

Function
REQ-012 For each sample, index_o SHALL be the index j where array_i[j*n +: n] is the maximum under signed comparison.
REQ-013 Ties SHALL resolve to the lowest index.
REQ-014 max_o SHALL equal array_i[index_o*n +: n] of the same sample.
REQ-015 Implementation SHALL be a binary compare-select tree of D levels, with one register stage after each level.
REQ-016 Level 0 SHALL tag each element with its constant index.
REQ-017 Each node SHALL compare its left (lower-index) and right candidates.
REQ-018 A node SHALL select the right candidate only if right > left (signed), otherwise the left candidate.
REQ-019 A level with an odd candidate count SHALL pass its last candidate through its register unchanged.
REQ-020 Latency SHALL be exactly D cycles: a sample with valid_i high at edge t SHALL appear with valid_o high after edge t+D-1 (D = 7 for k = 100).
REQ-021 The block SHALL accept a new sample every cycle; there is no backpressure.
REQ-022 valid SHALL travel in a shift register alongside the data, so valid_o is valid_i delayed by D.
REQ-023 Data registers SHALL load every cycle regardless of valid_i; index_o and max_o are don't-care while valid_o is low.
REQ-024 Comparison SHALL use the full n bits with no saturation.
REQ-025 Boundary: the most negative value (-2^(n-1)) SHALL lose to every other value.
REQ-026 Boundary: an all-equal array SHALL yield index 0.
REQ-027 Boundary: if the maximum is at index k-1, index_o SHALL be k-1.

Reset
REQ-028 While rst_ni is low, all valid pipeline bits SHALL clear to 0 immediately; valid_o = 0.
REQ-029 While rst_ni is low, all index and value pipeline registers SHALL clear to 0; index_o = 0, max_o = 0.
REQ-030 Samples in flight when reset asserts SHALL be discarded.
REQ-031 After rst_ni deasserts, the first valid_o SHALL appear D cycles after the first accepted valid_i.

Structure
REQ-032 Shared package argmax_pkg SHALL hold the default values of k and n and a candidate typedef (index field, signed value field), parameterised through localparams.
REQ-033 One sub-module argmax_cmp (combinational two-input signed compare-select, left wins ties) SHALL be instantiated once per tree node.
REQ-034 Tree levels SHALL be built with generate loops.
REQ-035 The design SHALL contain no latches and no combinational path from the inputs to the outputs.

Verification
REQ-036 Reset check: assert rst_ni low mid-stream -> valid_o = 0, index_o = 0, max_o = 0 at once; no stale valid_o after release.
REQ-037 Single max: k=100, n=8, all elements -5, element 37 = 12 -> index_o = 37, max_o = 12, D = 7 cycles after valid_i.
REQ-038 Ties and signedness: all elements 8'h80, elements 20 and 60 = 8'h7F -> index_o = 20, max_o = 127; all elements equal -> index_o = 0.
REQ-039 Edge index: element 99 = 0, all others -1 -> index_o = 99, max_o = 0.
REQ-040 Throughput: 100 back-to-back random samples ($random per element) -> each result has no element signed-greater than element index_o, and max_o matches that element; 100 valid_o pulses in order.
REQ-041 Bubbles: toggle valid_i in the pattern 1,0,0,1 -> valid_o reproduces the same pattern D cycles later, with matching results.

Source files
------------

// File: rtl/argmax_pkg.sv
// Shared defaults, candidate type and tree-sizing helper for the argmax
// compare-select tree.
package argmax_pkg;

    localparam int ARGMAX_K  = 100;
    localparam int ARGMAX_N  = 8;
    localparam int ARGMAX_IW = $clog2(ARGMAX_K);

    typedef struct packed {
        logic [ARGMAX_IW-1:0]       idx;
        logic signed [ARGMAX_N-1:0] val;
    } argmax_cand_t;

    // Candidates surviving after lvl halving levels: ceil(cnt / 2^lvl).
    function automatic int level_count(input int cnt, input int lvl);
        return (cnt + (1 << lvl) - 1) >> lvl;
    endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Two-input signed compare-select node; the left (lower-index) candidate
// wins ties.
module argmax_cmp #(
    parameter int IW = 7,
    parameter int N  = 8
) (
    input  logic [IW-1:0]       i_l_idx,
    input  logic signed [N-1:0] i_l_val,
    input  logic [IW-1:0]       i_r_idx,
    input  logic signed [N-1:0] i_r_val,
    output logic [IW-1:0]       o_idx,
    output logic signed [N-1:0] o_val
);

    logic w_take_r;

    assign w_take_r = i_r_val > i_l_val;
    assign o_idx    = w_take_r ? i_r_idx : i_l_idx;
    assign o_val    = w_take_r ? i_r_val : i_l_val;

endmodule

// File: rtl/argmax.sv
// Pipelined argmax over k signed n-bit elements: a binary compare-select
// tree with one register stage per level and a matching valid pipeline.
module argmax
    import argmax_pkg::*;
#(
    parameter int k = ARGMAX_K,
    parameter int n = ARGMAX_N,
    localparam int IW = $clog2(k),
    localparam int D  = $clog2(k)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    input  logic [k*n-1:0]      array_i,
    output logic                valid_o,
    output logic [IW-1:0]       index_o,
    output logic signed [n-1:0] max_o
);

    logic [IW-1:0]       w_idx0 [k];
    logic signed [n-1:0] w_val0 [k];

    for (genvar j = 0; j < k; j++) begin : g_tag
        assign w_idx0[j] = IW'(j);
        assign w_val0[j] = array_i[j*n +: n];
    end

    for (genvar l = 1; l <= D; l++) begin : g_lvl
        localparam int CI = level_count(k, l - 1);
        localparam int CO = level_count(k, l);

        logic [IW-1:0]       w_in_idx  [CI];
        logic signed [n-1:0] w_in_val  [CI];
        logic                w_in_vld;
        logic [IW-1:0]       w_sel_idx [CO];
        logic signed [n-1:0] w_sel_val [CO];
        logic [IW-1:0]       r_idx     [CO];
        logic signed [n-1:0] r_val     [CO];
        logic                r_vld;

        if (l == 1) begin : g_src
            assign w_in_idx = w_idx0;
            assign w_in_val = w_val0;
            assign w_in_vld = valid_i;
        end else begin : g_src
            assign w_in_idx = g_lvl[l-1].r_idx;
            assign w_in_val = g_lvl[l-1].r_val;
            assign w_in_vld = g_lvl[l-1].r_vld;
        end

        // An unpaired last candidate on an odd-sized level passes straight through.
        for (genvar j = 0; j < CO; j++) begin : g_node
            if (2*j + 1 < CI) begin : g_cmp
                argmax_cmp #(
                    .IW (IW),
                    .N  (n)
                ) u_cmp (
                    .i_l_idx (w_in_idx[2*j]),
                    .i_l_val (w_in_val[2*j]),
                    .i_r_idx (w_in_idx[2*j+1]),
                    .i_r_val (w_in_val[2*j+1]),
                    .o_idx   (w_sel_idx[j]),
                    .o_val   (w_sel_val[j])
                );
            end else begin : g_pass
                assign w_sel_idx[j] = w_in_idx[2*j];
                assign w_sel_val[j] = w_in_val[2*j];
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_vld <= 1'b0;
                for (int unsigned j = 0; j < CO; j++) begin
                    r_idx[j] <= '0;
                    r_val[j] <= '0;
                end
            end else begin
                r_vld <= w_in_vld;
                r_idx <= w_sel_idx;
                r_val <= w_sel_val;
            end
        end
    end

    assign valid_o = g_lvl[D].r_vld;
    assign index_o = g_lvl[D].r_idx[0];
    assign max_o   = g_lvl[D].r_val[0];

endmodule

// File: tb/tb_argmax.sv
// Self-checking bench for argmax: directed table, random stream, bubbles
// and mid-stream reset, scored against a plain linear-scan argmax model.
module tb_argmax;

    localparam int K  = 100;
    localparam int N  = 8;
    localparam int IW = $clog2(K);
    localparam int D  = $clog2(K);

    logic                clk_i   = 1'b0;
    logic                rst_ni  = 1'b0;
    logic                valid_i = 1'b0;
    logic [K*N-1:0]      array_i = '0;
    logic                valid_o;
    logic [IW-1:0]       index_o;
    logic signed [N-1:0] max_o;

    always #5 clk_i = ~clk_i;

    argmax #(
        .k (K),
        .n (N)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .array_i (array_i),
        .valid_o (valid_o),
        .index_o (index_o),
        .max_o   (max_o)
    );

    typedef struct {
        string          name;
        logic [K*N-1:0] arr;
        int             idx;
        int             mx;
    } vec_t;

    typedef struct {
        string          name;
        logic [K*N-1:0] arr;
        int             idx;
        int             mx;
        int             due;
    } exp_t;

    exp_t q[$];
    vec_t vecs[7];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   rand_seen = 0;

    task automatic check(input string nm, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic void ref_model(input logic [K*N-1:0] a, output int idx, output int mx);
        idx = 0;
        mx  = $signed(a[N-1:0]);
        for (int j = 1; j < K; j++) begin
            int v;
            v = $signed(a[j*N +: N]);
            if (v > mx) begin
                mx  = v;
                idx = j;
            end
        end
    endfunction

    function automatic logic [K*N-1:0] fill_all(input logic [N-1:0] v);
        logic [K*N-1:0] a;
        for (int j = 0; j < K; j++) a[j*N +: N] = v;
        return a;
    endfunction

    function automatic logic [K*N-1:0] set_el(input logic [K*N-1:0] a, input int j, input logic [N-1:0] v);
        logic [K*N-1:0] r;
        r = a;
        r[j*N +: N] = v;
        return r;
    endfunction

    function automatic logic [K*N-1:0] rand_arr();
        logic [K*N-1:0] a;
        for (int j = 0; j < K; j++) a[j*N +: N] = N'($urandom);
        return a;
    endfunction

    task automatic send(input logic v, input logic [K*N-1:0] a, input string nm, input int ei, input int em);
        exp_t e;
        @(negedge clk_i);
        valid_i = v;
        array_i = a;
        if (v) begin
            e.name = nm;
            e.arr  = a;
            e.idx  = ei;
            e.mx   = em;
            e.due  = cyc + D;
            q.push_back(e);
        end
    endtask

    task automatic send_rand(input string nm);
        logic [K*N-1:0] a;
        int ei, em;
        a = rand_arr();
        ref_model(a, ei, em);
        send(1'b1, a, nm, ei, em);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) send(1'b0, '0, "", 0, 0);
    endtask

    always @(posedge clk_i) begin
        exp_t e;
        int   ix, bad;
        cyc = cyc + 1;
        #1;
        while (q.size() > 0 && q[0].due < cyc) begin
            check({q[0].name, " missing valid_o"}, 0, 1);
            void'(q.pop_front());
        end
        if (valid_o) begin
            if (q.size() == 0) begin
                check("unexpected valid_o", 1, 0);
            end else begin
                e = q.pop_front();
                check({e.name, " latency"}, cyc, e.due);
                check({e.name, " index_o"}, int'(index_o), e.idx);
                check({e.name, " max_o"}, int'(max_o), e.mx);
                if (e.name == "rand") begin
                    rand_seen++;
                    ix  = int'(index_o);
                    bad = 0;
                    if (ix < K) begin
                        for (int j = 0; j < K; j++)
                            if ($signed(e.arr[j*N +: N]) > $signed(e.arr[ix*N +: N])) bad++;
                        check("rand max_o vs element", int'(max_o), int'($signed(e.arr[ix*N +: N])));
                    end else begin
                        bad = 1;
                    end
                    check("rand no greater element", bad, 0);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{"single_max", set_el(fill_all(8'hFB), 37, 8'd12), 37, 12};
        vecs[1] = '{"tie_sign", set_el(set_el(fill_all(8'h80), 20, 8'h7F), 60, 8'h7F), 20, 127};
        vecs[2] = '{"all_equal", fill_all(8'h33), 0, 51};
        vecs[3] = '{"edge_idx", set_el(fill_all(8'hFF), 99, 8'h00), 99, 0};
        vecs[4] = '{"all_min", fill_all(8'h80), 0, -128};
        vecs[5] = '{"min_loses", set_el(fill_all(8'h80), 50, 8'h81), 50, -127};
        vecs[6] = '{"tail_tie", set_el(set_el(fill_all(8'h00), 98, 8'h05), 99, 8'h05), 98, 5};

        #1;
        check("reset valid_o", int'(valid_o), 0);
        check("reset index_o", int'(index_o), 0);
        check("reset max_o", int'(max_o), 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 7; i++)
            send(1'b1, vecs[i].arr, vecs[i].name, vecs[i].idx, vecs[i].mx);
        idle(D + 2);

        for (int i = 0; i < 100; i++) send_rand("rand");
        idle(D + 2);
        check("rand pulse count", rand_seen, 100);

        send_rand("bubble");
        idle(2);
        send_rand("bubble");
        idle(D + 2);

        for (int i = 0; i < 3; i++) send_rand("flushed");
        @(negedge clk_i);
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        #1;
        check("midreset valid_o", int'(valid_o), 0);
        check("midreset index_o", int'(index_o), 0);
        check("midreset max_o", int'(max_o), 0);
        q.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        idle(D + 3);
        send_rand("post_reset");
        idle(D + 2);

        check("queue drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
